// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the conditioned controls.
// No handshake: btn_raw is a free-running level, all outputs are levels or 1-cycle strobes.
interface button_conditioner_if #(
   parameter int NUM_BTN = 3
);
   logic [NUM_BTN-1:0]   btn_raw;
   logic [NUM_BTN-1:0]   btn_level;
   logic [NUM_BTN-1:0]   btn_press;
   logic [NUM_BTN-1:0]   btn_release;
   logic                 any_press;
   logic [2*NUM_BTN-1:0] dbg_state;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, any_press, dbg_state
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, any_press, dbg_state
   );
endinterface

// File: rtl/button_conditioner.sv
// Two-flop synchroniser plus per-channel debounce FSM for push-buttons.
// Emits a debounced level and single-cycle press/release strobes per channel.
module button_conditioner #(
   parameter int NUM_BTN   = 3,
   parameter int DB_CYCLES = 2_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   button_conditioner_if.slave    bus
);
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   logic [NUM_BTN-1:0] level_w;
   logic [NUM_BTN-1:0] press_w;
   logic [NUM_BTN-1:0] release_w;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      logic             meta_q;
      logic             sync_q;
      state_e           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             level_q;
      logic             press_q;
      logic             release_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
         end else begin
            meta_q <= bus.btn_raw[g];
            sync_q <= meta_q;
         end
      end

      // Any disagreement with the target level drops back to the stable state,
      // so a partial count never survives a bounce.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
               IDLE: begin
                  if (sync_q) begin
                     state_q <= WAIT_PRESS;
                     cnt_q   <= CNT_ONE;
                  end else begin
                     cnt_q   <= '0;
                  end
               end
               WAIT_PRESS: begin
                  if (!sync_q) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q + CNT_ONE;
                  end
               end
               PRESSED: begin
                  if (!sync_q) begin
                     state_q <= WAIT_RELEASE;
                     cnt_q   <= CNT_ONE;
                  end
               end
               WAIT_RELEASE: begin
                  if (sync_q) begin
                     state_q <= PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q   <= IDLE;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q     <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign level_w[g]              = level_q;
      assign press_w[g]              = press_q;
      assign release_w[g]            = release_q;
      assign bus.dbg_state[2*g +: 2] = state_q;
   end

   assign bus.btn_level   = level_w;
   assign bus.btn_press   = press_w;
   assign bus.btn_release = release_w;
   assign bus.any_press   = |press_w;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4 and three channels.
module tb_button_conditioner;
   localparam int NUM_BTN   = 3;
   localparam int DB_CYCLES = 4;

   typedef struct {
      logic [2:0] raw;
      logic [2:0] lvl;
      logic [2:0] prs;
      logic [2:0] rel;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   button_conditioner_if #(.NUM_BTN(NUM_BTN)) bus_if ();

   button_conditioner #(
      .NUM_BTN  (NUM_BTN),
      .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] outs();
      return {bus_if.btn_level, bus_if.btn_press, bus_if.btn_release, bus_if.any_press};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got lvl/prs/rel/any=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic [5:0] exp);
      checks++;
      if (bus_if.dbg_state !== exp) begin
         failures++;
         $display("FAIL %s: got state=%b expected %b", name, bus_if.dbg_state, exp);
      end
   endtask

   function automatic logic [9:0] expect_of(input logic [2:0] lvl, input logic [2:0] prs,
                                            input logic [2:0] rel);
      return {lvl, prs, rel, |prs};
   endfunction

   task automatic add(input logic [2:0] raw, input logic [2:0] lvl,
                      input logic [2:0] prs, input logic [2:0] rel);
      vec_t v;
      v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel;
      vecs.push_back(v);
   endtask

   task automatic add_rep(input logic [2:0] raw, input logic [2:0] lvl, input int n);
      for (int i = 0; i < n; i++) add(raw, lvl, 3'b000, 3'b000);
   endtask

   initial begin
      // Clean press of channel 0: strobe and level on edge 5.
      add_rep(3'b001, 3'b000, 5); add(3'b001, 3'b001, 3'b001, 3'b000); add_rep(3'b001, 3'b001, 2);
      // Release of channel 0.
      add_rep(3'b000, 3'b001, 5); add(3'b000, 3'b000, 3'b000, 3'b001); add_rep(3'b000, 3'b000, 2);
      // Simultaneous press and release of channels 0 and 2.
      add_rep(3'b101, 3'b000, 5); add(3'b101, 3'b101, 3'b101, 3'b000); add_rep(3'b101, 3'b101, 2);
      add_rep(3'b000, 3'b101, 5); add(3'b000, 3'b000, 3'b000, 3'b101); add_rep(3'b000, 3'b000, 2);
      // Pulse of DB_CYCLES-1 clocks on channel 1: rejected.
      add_rep(3'b010, 3'b000, 3); add_rep(3'b000, 3'b000, 6);
      // Pulse of exactly DB_CYCLES clocks: accepted, then released.
      add_rep(3'b010, 3'b000, 4); add_rep(3'b000, 3'b000, 1);
      add(3'b000, 3'b010, 3'b010, 3'b000); add_rep(3'b000, 3'b010, 3);
      add(3'b000, 3'b000, 3'b000, 3'b010); add_rep(3'b000, 3'b000, 2);

      bus_if.btn_raw = 3'b000;
      #1;
      rst_n = 1'b0;
      bus_if.btn_raw = 3'b111;
      #1;
      check("reset_async", outs(), '0);
      check_state("reset_state", 6'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_hold%0d", i), outs(), '0);
      end
      bus_if.btn_raw = 3'b000;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_reset%0d", i), outs(), '0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         bus_if.btn_raw = vecs[i].raw;
         tick();
         check($sformatf("vec%0d", i), outs(), expect_of(vecs[i].lvl, vecs[i].prs, vecs[i].rel));
      end

      // Bounce on channel 1: high 3, low 1, then held high.
      bus_if.btn_raw = 3'b010;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bounce_hi%0d", i), outs(), '0);
      end
      bus_if.btn_raw = 3'b000;
      tick();
      check("bounce_lo", outs(), '0);
      bus_if.btn_raw = 3'b010;
      for (int f = 0; f < 8; f++) begin
         tick();
         check($sformatf("bounce_f%0d", f), outs(),
               expect_of((f >= 5) ? 3'b010 : 3'b000, (f == 5) ? 3'b010 : 3'b000, 3'b000));
      end

      // Reset in the middle of a channel 0 count while channel 1 is pressed.
      bus_if.btn_raw = 3'b011;
      for (int e = 0; e < 4; e++) begin
         tick();
         check($sformatf("midcnt_e%0d", e), outs(), expect_of(3'b010, 3'b000, 3'b000));
      end
      rst_n = 1'b0;
      #2;
      check("midcnt_async_reset", outs(), '0);
      check_state("midcnt_state", 6'b0);
      #2;
      rst_n = 1'b1;
      for (int f = 0; f < 8; f++) begin
         tick();
         check($sformatf("held_f%0d", f), outs(),
               expect_of((f >= 5) ? 3'b011 : 3'b000, (f == 5) ? 3'b011 : 3'b000, 3'b000));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
